tx_arbiter: RTL and testbench

- Shares the single USB transmit FSM between two requesters: the protocol/RX side, which needs ACK/NAK handshakes, and the AHB-side data path, which needs DATA packets.
- Selects a winner, issues the tx_packet code, and waits for tx_done.
- Enforces an inter-packet gap and a watchdog timeout, and returns per-requester completion pulses.
- Sits between the protocol controller / AHB slave and the transmit FSM.

---
 rtl/tx_arbiter_if.sv | 25 ++
 rtl/tx_arbiter.sv | 122 ++++++++++++
 tb/tb_tx_arbiter.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/tx_arbiter_if.sv
// Request/response bundle between the protocol controller, the AHB data path
// and the arbiter that shares the USB transmit FSM between them.
interface tx_arbiter_if;
  logic       hs_req;
  logic       hs_nak;
  logic       data_req;
  logic [6:0] data_size;
  logic       tx_done;
  logic [1:0] tx_packet;
  logic [6:0] tx_packet_data_size;
  logic       hs_done;
  logic       data_done;
  logic       timeout_err;
  logic       busy;

  modport master (
    output hs_req, hs_nak, data_req, data_size, tx_done,
    input  tx_packet, tx_packet_data_size, hs_done, data_done, timeout_err, busy
  );

  modport slave (
    input  hs_req, hs_nak, data_req, data_size, tx_done,
    output tx_packet, tx_packet_data_size, hs_done, data_done, timeout_err, busy
  );
endinterface

// File: rtl/tx_arbiter.sv
// Arbitrates the single USB transmit FSM between handshake and data requesters,
// with a one-cycle packet issue, a watchdog timeout and a post-transfer gap.
module tx_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 4,
  parameter int MAX_HS_STREAK  = 3
) (
  input  logic         clk,
  input  logic         rst,
  tx_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_HS, OWN_DATA} owner_t;

  localparam logic [1:0]  PKT_IDLE   = 2'b00;
  localparam logic [1:0]  PKT_DATA   = 2'b01;
  localparam logic [1:0]  PKT_ACK    = 2'b10;
  localparam logic [1:0]  PKT_NAK    = 2'b11;
  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]  GAP_LIMIT  = 9'(GAP_CYCLES);
  localparam logic [3:0]  STREAK_MAX = 4'(MAX_HS_STREAK);

  state_t      state_q;
  owner_t      owner_q;
  logic [1:0]  txPacket_q;
  logic [6:0]  dataSize_q;
  logic        hsDone_q;
  logic        dataDone_q;
  logic        timeoutErr_q;
  logic        busy_q;
  logic [3:0]  streak_q;
  logic [15:0] timer_q;
  logic [8:0]  gapCnt_q;

  logic        grantData_d;
  logic        grantHs_d;
  logic [3:0]  streakHs_d;

  // Data is forced through once handshakes have won MAX_HS_STREAK times in a row.
  always_comb begin
    grantData_d = bus.data_req && (!bus.hs_req || (streak_q == STREAK_MAX));
    grantHs_d   = bus.hs_req && !grantData_d;
    streakHs_d  = '0;
    if (bus.data_req) begin
      streakHs_d = (streak_q == STREAK_MAX) ? streak_q : streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= OWN_NONE;
      txPacket_q   <= PKT_IDLE;
      dataSize_q   <= '0;
      hsDone_q     <= 1'b0;
      dataDone_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
      busy_q       <= 1'b0;
      streak_q     <= '0;
      timer_q      <= '0;
      gapCnt_q     <= '0;
    end else begin
      hsDone_q     <= 1'b0;
      dataDone_q   <= 1'b0;
      timeoutErr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grantData_d) begin
            owner_q    <= OWN_DATA;
            txPacket_q <= PKT_DATA;
            dataSize_q <= bus.data_size;
            streak_q   <= '0;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end else if (grantHs_d) begin
            owner_q    <= OWN_HS;
            txPacket_q <= bus.hs_nak ? PKT_NAK : PKT_ACK;
            streak_q   <= streakHs_d;
            busy_q     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          txPacket_q <= PKT_IDLE;
          timer_q    <= '0;
          state_q    <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A tx_done on the final timer cycle still counts as a clean completion.
          if (bus.tx_done || (timer_q == TIMER_LAST)) begin
            hsDone_q     <= (owner_q == OWN_HS);
            dataDone_q   <= (owner_q == OWN_DATA);
            timeoutErr_q <= !bus.tx_done;
            owner_q      <= OWN_NONE;
            gapCnt_q     <= '0;
            state_q      <= GAP;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        GAP: begin
          if ((gapCnt_q + 9'd1) >= GAP_LIMIT) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gapCnt_q <= gapCnt_q + 9'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.tx_packet           = txPacket_q;
  assign bus.tx_packet_data_size = dataSize_q;
  assign bus.hs_done             = hsDone_q;
  assign bus.data_done           = dataDone_q;
  assign bus.timeout_err         = timeoutErr_q;
  assign bus.busy                = busy_q;

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter with TIMEOUT_CYCLES=16, GAP_CYCLES=4,
// MAX_HS_STREAK=3; expected values are hand-derived cycle by cycle.
module tb_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  tx_arbiter_if bus ();

  tx_arbiter #(
    .TIMEOUT_CYCLES (16),
    .GAP_CYCLES     (4),
    .MAX_HS_STREAK  (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic hs, input logic nak, input logic dreq,
                               input logic [6:0] size, input logic done);
    bus.hs_req    = hs;
    bus.hs_nak    = nak;
    bus.data_req  = dreq;
    bus.data_size = size;
    bus.tx_done   = done;
  endtask

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic checkValue(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [1:0] expCode [5];
    logic       hsReq;
    logic       dataReq;
    int         waited;
    int         expWait;

    expCode[0] = 2'b10;
    expCode[1] = 2'b10;
    expCode[2] = 2'b10;
    expCode[3] = 2'b01;
    expCode[4] = 2'b10;

    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    rst = 1'b1;
    tick(2);
    checkValue("reset_tx_packet", {5'b0, bus.tx_packet}, 7'd0);
    checkValue("reset_size", bus.tx_packet_data_size, 7'd0);
    checkOutput("reset_busy", bus.busy, 1'b0);
    checkOutput("reset_hs_done", bus.hs_done, 1'b0);
    checkOutput("reset_data_done", bus.data_done, 1'b0);
    checkOutput("reset_timeout", bus.timeout_err, 1'b0);
    rst = 1'b0;
    tick(1);

    // Single ACK
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(1);
    checkValue("ack_issue_code", {5'b0, bus.tx_packet}, 7'd2);
    checkOutput("ack_issue_busy", bus.busy, 1'b1);
    tick(1);
    checkValue("ack_code_one_cycle", {5'b0, bus.tx_packet}, 7'd0);
    tick(8);
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b1);
    checkOutput("ack_no_early_done", bus.hs_done, 1'b0);
    tick(1);
    checkOutput("ack_hs_done", bus.hs_done, 1'b1);
    checkOutput("ack_data_done", bus.data_done, 1'b0);
    checkOutput("ack_timeout", bus.timeout_err, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(1);
    checkOutput("ack_pulse_single", bus.hs_done, 1'b0);
    tick(2);
    checkOutput("ack_gap_busy", bus.busy, 1'b1);
    tick(1);
    checkOutput("ack_idle_busy", bus.busy, 1'b0);

    // Simultaneous NAK and DATA(64): handshake first, then data after the gap
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd64, 1'b0);
    tick(1);
    checkValue("sim_nak_code", {5'b0, bus.tx_packet}, 7'd3);
    checkValue("sim_size_untouched", bus.tx_packet_data_size, 7'd0);
    tick(3);
    applyStimulus(1'b1, 1'b1, 1'b1, 7'd64, 1'b1);
    tick(1);
    checkOutput("sim_hs_done", bus.hs_done, 1'b1);
    checkOutput("sim_no_data_done", bus.data_done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd64, 1'b0);
    tick(4);
    checkValue("sim_gap_no_issue", {5'b0, bus.tx_packet}, 7'd0);
    checkOutput("sim_gap_idle", bus.busy, 1'b0);
    tick(1);
    checkValue("sim_data_code", {5'b0, bus.tx_packet}, 7'd1);
    checkValue("sim_data_size", bus.tx_packet_data_size, 7'd64);

    // tx_done on the exact timeout cycle counts as completion
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 1'b0);
    tick(16);
    checkOutput("edge_no_early_done", bus.data_done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 7'd5, 1'b1);
    tick(1);
    checkOutput("edge_data_done", bus.data_done, 1'b1);
    checkOutput("edge_no_timeout", bus.timeout_err, 1'b0);
    checkValue("edge_size_held", bus.tx_packet_data_size, 7'd64);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(4);
    checkOutput("edge_idle", bus.busy, 1'b0);

    // Timeout on a DATA transfer with no tx_done
    applyStimulus(1'b0, 1'b0, 1'b1, 7'h55, 1'b0);
    tick(1);
    checkValue("to_data_code", {5'b0, bus.tx_packet}, 7'd1);
    checkValue("to_data_size", bus.tx_packet_data_size, 7'h55);
    tick(16);
    checkOutput("to_not_yet", bus.data_done, 1'b0);
    checkOutput("to_busy_wait", bus.busy, 1'b1);
    tick(1);
    checkOutput("to_data_done", bus.data_done, 1'b1);
    checkOutput("to_timeout_err", bus.timeout_err, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(1);
    checkOutput("to_pulse_single", bus.timeout_err, 1'b0);
    checkOutput("to_gap_busy", bus.busy, 1'b1);
    tick(3);
    checkOutput("to_idle", bus.busy, 1'b0);

    // Stray tx_done in IDLE
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
    tick(1);
    checkOutput("stray_hs_done", bus.hs_done, 1'b0);
    checkOutput("stray_data_done", bus.data_done, 1'b0);
    checkOutput("stray_busy", bus.busy, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(1);

    // Starvation guard: expected grant order HS,HS,HS,DATA,HS
    hsReq   = 1'b1;
    dataReq = 1'b1;
    applyStimulus(hsReq, 1'b0, dataReq, 7'd9, 1'b0);
    for (int g = 0; g < 5; g++) begin
      waited = 0;
      while (bus.tx_packet == 2'b00 && waited < 20) begin
        tick(1);
        waited++;
      end
      expWait = (g == 0) ? 1 : 5;
      checkValue($sformatf("starve_code_%0d", g), {5'b0, bus.tx_packet}, {5'b0, expCode[g]});
      checkValue($sformatf("starve_latency_%0d", g), 7'(waited), 7'(expWait));
      tick(1);
      applyStimulus(hsReq, 1'b0, dataReq, 7'd9, 1'b1);
      tick(1);
      checkOutput($sformatf("starve_hs_done_%0d", g), bus.hs_done, expCode[g] == 2'b10);
      checkOutput($sformatf("starve_data_done_%0d", g), bus.data_done, expCode[g] == 2'b01);
      if (g == 3) dataReq = 1'b0;
      if (g == 4) hsReq = 1'b0;
      applyStimulus(hsReq, 1'b0, dataReq, 7'd9, 1'b0);
    end
    tick(4);
    checkOutput("starve_idle", bus.busy, 1'b0);

    // Reset in the middle of WAIT_DONE, then a late tx_done
    applyStimulus(1'b1, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(1);
    checkValue("rst_issue_code", {5'b0, bus.tx_packet}, 7'd2);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checkValue("rst_tx_packet", {5'b0, bus.tx_packet}, 7'd0);
    checkValue("rst_size", bus.tx_packet_data_size, 7'd0);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_hs_done", bus.hs_done, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b1);
    tick(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7'd0, 1'b0);
    checkOutput("rst_late_done_none", bus.hs_done, 1'b0);
    checkOutput("rst_late_busy", bus.busy, 1'b0);
    tick(1);
    checkOutput("rst_late_done_none2", bus.hs_done, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
